// File: rtl/victim_cache_controller.sv
// Tag, valid and dirty bookkeeping plus insert/writeback/flush sequencing for the dcache victim cache.
// Define VC_STATS_EN to add saturating take-hit and writeback counters (hit_cnt_o, wb_cnt_o).
module victim_cache_controller #(
    parameter int VC_ENTRIES = 4,
    parameter int TAG_BITS   = 26,
    localparam int IDX_W     = $clog2(VC_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TAG_BITS-1:0] lookup_addr_i,
    output logic                victim_hit_o,
    output logic [IDX_W-1:0]    hit_idx_o,
    input  logic                insert_req_i,
    input  logic [TAG_BITS-1:0] insert_addr_i,
    input  logic                insert_dirty_i,
    output logic                insert_ready_o,
    input  logic                take_i,
    output logic                vc_wr_o,
    output logic [IDX_W-1:0]    vc_wr_idx_o,
    output logic [IDX_W-1:0]    vc_rd_idx_o,
    output logic                mem_req_o,
    output logic                mem_wr_o,
    output logic [TAG_BITS-1:0] mem_addr_o,
    input  logic                mem_ack_i,
    output logic                mem_kill_o,
    input  logic                kill_i,
    input  logic                flush_i,
    output logic                flush_done_o,
    output logic                busy_o
`ifdef VC_STATS_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         wb_cnt_o
`endif
);
    typedef enum logic [2:0] {VC_IDLE, VC_WB, VC_INSERT, VC_FLUSH_SCAN, VC_FLUSH_WB} state_t;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VC_ENTRIES - 1);

    state_t                state_reg, state_next;
    logic [TAG_BITS-1:0]   tag_reg [VC_ENTRIES];
    logic [VC_ENTRIES-1:0] valid_reg, dirty_reg;
    logic [IDX_W-1:0]      rr_reg, rr_next, tgt_reg, tgt_next, scan_reg, scan_next;

    logic [VC_ENTRIES-1:0] match;
    logic                  any_match, any_free, swap;
    logic [IDX_W-1:0]      match_idx, free_idx, target;
    logic                  ins_en, inv_en;
    logic [IDX_W-1:0]      ins_idx, inv_idx;

    generate
        for (genvar gi = 0; gi < VC_ENTRIES; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (tag_reg[gi] == lookup_addr_i);
        end
    endgenerate

    // Descending scans so the lowest qualifying index wins.
    always_comb begin
        match_idx = '0;
        free_idx  = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (match[i])
                match_idx = IDX_W'(i);
            if (!valid_reg[i])
                free_idx = IDX_W'(i);
        end
    end

    assign any_match    = |match;
    assign any_free     = ~&valid_reg;
    assign victim_hit_o = any_match && (state_reg == VC_IDLE);
    assign hit_idx_o    = match_idx;
    assign busy_o       = (state_reg != VC_IDLE);

    always_comb begin
        state_next     = state_reg;
        tgt_next       = tgt_reg;
        scan_next      = scan_reg;
        rr_next        = rr_reg;
        swap           = 1'b0;
        target         = '0;
        ins_en         = 1'b0;
        ins_idx        = '0;
        inv_en         = 1'b0;
        inv_idx        = '0;
        insert_ready_o = 1'b0;
        vc_wr_o        = 1'b0;
        vc_wr_idx_o    = '0;
        vc_rd_idx_o    = '0;
        mem_req_o      = 1'b0;
        mem_wr_o       = 1'b0;
        mem_addr_o     = '0;
        mem_kill_o     = 1'b0;
        flush_done_o   = 1'b0;

        if (kill_i) begin
            state_next = VC_IDLE;
            mem_kill_o = (state_reg == VC_WB) || (state_reg == VC_FLUSH_WB);
        end else begin
            case (state_reg)
                VC_IDLE: begin
                    if (flush_i) begin
                        state_next = VC_FLUSH_SCAN;
                        scan_next  = '0;
                    end else if (insert_req_i) begin
                        if (take_i && any_match) begin
                            swap   = 1'b1;
                            target = match_idx;
                        end else if (any_free) begin
                            target = free_idx;
                        end else begin
                            target = rr_reg;
                        end
                        // A swapped-out line leaves with the dcache, so its slot never needs a writeback.
                        if (!swap && valid_reg[target] && dirty_reg[target]) begin
                            state_next = VC_WB;
                            tgt_next   = target;
                        end else begin
                            ins_en         = 1'b1;
                            ins_idx        = target;
                            vc_wr_o        = 1'b1;
                            vc_wr_idx_o    = target;
                            insert_ready_o = 1'b1;
                            if (target == rr_reg)
                                rr_next = rr_reg + IDX_W'(1);
                        end
                    end else if (take_i && any_match) begin
                        inv_en  = 1'b1;
                        inv_idx = match_idx;
                    end
                end
                VC_WB: begin
                    mem_req_o   = 1'b1;
                    mem_wr_o    = 1'b1;
                    mem_addr_o  = tag_reg[tgt_reg];
                    vc_rd_idx_o = tgt_reg;
                    if (mem_ack_i)
                        state_next = VC_INSERT;
                end
                VC_INSERT: begin
                    ins_en         = 1'b1;
                    ins_idx        = tgt_reg;
                    vc_wr_o        = 1'b1;
                    vc_wr_idx_o    = tgt_reg;
                    insert_ready_o = 1'b1;
                    if (tgt_reg == rr_reg)
                        rr_next = rr_reg + IDX_W'(1);
                    state_next = VC_IDLE;
                end
                VC_FLUSH_SCAN: begin
                    if (valid_reg[scan_reg] && dirty_reg[scan_reg]) begin
                        state_next = VC_FLUSH_WB;
                    end else begin
                        inv_en  = 1'b1;
                        inv_idx = scan_reg;
                        if (scan_reg == LAST_IDX) begin
                            flush_done_o = 1'b1;
                            rr_next      = '0;
                            state_next   = VC_IDLE;
                        end else begin
                            scan_next = scan_reg + IDX_W'(1);
                        end
                    end
                end
                VC_FLUSH_WB: begin
                    mem_req_o   = 1'b1;
                    mem_wr_o    = 1'b1;
                    mem_addr_o  = tag_reg[scan_reg];
                    vc_rd_idx_o = scan_reg;
                    // Dirty entry stays valid until its writeback is acknowledged, so a kill loses nothing.
                    if (mem_ack_i) begin
                        inv_en  = 1'b1;
                        inv_idx = scan_reg;
                        if (scan_reg == LAST_IDX) begin
                            flush_done_o = 1'b1;
                            rr_next      = '0;
                            state_next   = VC_IDLE;
                        end else begin
                            scan_next  = scan_reg + IDX_W'(1);
                            state_next = VC_FLUSH_SCAN;
                        end
                    end
                end
                default: state_next = VC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= VC_IDLE;
            valid_reg <= '0;
            dirty_reg <= '0;
            rr_reg    <= '0;
            tgt_reg   <= '0;
            scan_reg  <= '0;
            for (int i = 0; i < VC_ENTRIES; i++)
                tag_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            tgt_reg   <= tgt_next;
            scan_reg  <= scan_next;
            for (int i = 0; i < VC_ENTRIES; i++) begin
                if (ins_en && ins_idx == IDX_W'(i)) begin
                    tag_reg[i]   <= insert_addr_i;
                    valid_reg[i] <= 1'b1;
                    dirty_reg[i] <= insert_dirty_i;
                end else if (inv_en && inv_idx == IDX_W'(i)) begin
                    valid_reg[i] <= 1'b0;
                    dirty_reg[i] <= 1'b0;
                end
            end
        end
    end

`ifdef VC_STATS_EN
    logic take_acc, wb_ack;
    // Every take with a hit in idle is accepted, whether alone or as a swap.
    assign take_acc = (state_reg == VC_IDLE) && !kill_i && !flush_i && take_i && any_match;
    assign wb_ack   = mem_req_o && mem_ack_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_o <= '0;
            wb_cnt_o  <= '0;
        end else begin
            if (take_acc && hit_cnt_o != 32'hFFFF_FFFF)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (wb_ack && wb_cnt_o != 32'hFFFF_FFFF)
                wb_cnt_o <= wb_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_victim_cache_controller.sv
// Directed bench for victim_cache_controller: insert, replacement, writeback, swap, flush, kill and reset.
module tb_victim_cache_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [25:0] lookup_addr_i;
    logic        victim_hit_o;
    logic [1:0]  hit_idx_o;
    logic        insert_req_i;
    logic [25:0] insert_addr_i;
    logic        insert_dirty_i;
    logic        insert_ready_o;
    logic        take_i;
    logic        vc_wr_o;
    logic [1:0]  vc_wr_idx_o;
    logic [1:0]  vc_rd_idx_o;
    logic        mem_req_o;
    logic        mem_wr_o;
    logic [25:0] mem_addr_o;
    logic        mem_ack_i;
    logic        mem_kill_o;
    logic        kill_i;
    logic        flush_i;
    logic        flush_done_o;
    logic        busy_o;
`ifdef VC_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] wb_cnt_o;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    victim_cache_controller dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_addr_i(lookup_addr_i), .victim_hit_o(victim_hit_o), .hit_idx_o(hit_idx_o),
        .insert_req_i(insert_req_i), .insert_addr_i(insert_addr_i),
        .insert_dirty_i(insert_dirty_i), .insert_ready_o(insert_ready_o),
        .take_i(take_i), .vc_wr_o(vc_wr_o), .vc_wr_idx_o(vc_wr_idx_o), .vc_rd_idx_o(vc_rd_idx_o),
        .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_kill_o(mem_kill_o), .kill_i(kill_i),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .busy_o(busy_o)
`ifdef VC_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [25:0] a, input logic exp_hit, input logic [1:0] exp_idx);
        lookup_addr_i = a;
        #1;
        $display("lookup 0x%0h hit=%0d idx=%0d", a, victim_hit_o, hit_idx_o);
        chk("lookup_hit", {31'd0, victim_hit_o}, {31'd0, exp_hit});
        if (exp_hit)
            chk("lookup_idx", {30'd0, hit_idx_o}, {30'd0, exp_idx});
    endtask

    // Single-cycle accepted insert (target clean or invalid).
    task automatic ins_ok(input logic [25:0] a, input logic d, input logic [1:0] exp_idx);
        insert_req_i = 1'b1; insert_addr_i = a; insert_dirty_i = d;
        #1;
        $display("insert 0x%0h dirty=%0d wr=%0d idx=%0d rdy=%0d", a, d, vc_wr_o, vc_wr_idx_o, insert_ready_o);
        chk("ins_wr", {31'd0, vc_wr_o}, 32'd1);
        chk("ins_idx", {30'd0, vc_wr_idx_o}, {30'd0, exp_idx});
        chk("ins_rdy", {31'd0, insert_ready_o}, 32'd1);
        chk("ins_nomem", {31'd0, mem_req_o}, 32'd0);
        tick();
        insert_req_i = 1'b0; insert_dirty_i = 1'b0;
    endtask

    // Take the hit line at t_addr and insert a in the same cycle.
    task automatic swap_ins(input logic [25:0] t_addr, input logic [25:0] a, input logic d,
                            input logic [1:0] exp_idx);
        lookup_addr_i = t_addr; take_i = 1'b1;
        insert_req_i = 1'b1; insert_addr_i = a; insert_dirty_i = d;
        #1;
        $display("swap take 0x%0h insert 0x%0h idx=%0d rdy=%0d", t_addr, a, vc_wr_idx_o, insert_ready_o);
        chk("swap_hit", {31'd0, victim_hit_o}, 32'd1);
        chk("swap_idx", {30'd0, vc_wr_idx_o}, {30'd0, exp_idx});
        chk("swap_rdy", {31'd0, insert_ready_o}, 32'd1);
        chk("swap_nomem", {31'd0, mem_req_o}, 32'd0);
        tick();
        take_i = 1'b0; insert_req_i = 1'b0; insert_dirty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; lookup_addr_i = '0; insert_req_i = 1'b0; insert_addr_i = '0;
        insert_dirty_i = 1'b0; take_i = 1'b0; mem_ack_i = 1'b0; kill_i = 1'b0; flush_i = 1'b0;
        do_reset();

        // Reset state
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_hit", {31'd0, victim_hit_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_wr", {31'd0, vc_wr_o}, 32'd0);
        chk("rst_rdy", {31'd0, insert_ready_o}, 32'd0);
        chk("rst_done", {31'd0, flush_done_o}, 32'd0);
        chk("rst_kill", {31'd0, mem_kill_o}, 32'd0);

        // First insert and lookup
        ins_ok(26'h100, 1'b0, 2'd0);
        lookup(26'h100, 1'b1, 2'd0);

        // Fill clean, round-robin replacement of idx 0 (rr 0 -> 1)
        ins_ok(26'h200, 1'b0, 2'd1);
        ins_ok(26'h300, 1'b0, 2'd2);
        ins_ok(26'h400, 1'b0, 2'd3);
        ins_ok(26'h500, 1'b0, 2'd0);
        lookup(26'h100, 1'b0, 2'd0);
        lookup(26'h500, 1'b1, 2'd0);

        // Refill with idx 1 dirty, rr ends at 1
        do_reset();
        ins_ok(26'h100, 1'b0, 2'd0);
        ins_ok(26'h200, 1'b1, 2'd1);
        ins_ok(26'h300, 1'b0, 2'd2);
        ins_ok(26'h400, 1'b0, 2'd3);
        ins_ok(26'h500, 1'b0, 2'd0);

        // Insert onto dirty victim at rr=1: 3-cycle writeback then write
        insert_req_i = 1'b1; insert_addr_i = 26'h600; insert_dirty_i = 1'b0; lookup_addr_i = 26'h500;
        #1;
        chk("wb_idle_rdy", {31'd0, insert_ready_o}, 32'd0);
        chk("wb_idle_wr", {31'd0, vc_wr_o}, 32'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) mem_ack_i = 1'b1;
            #1;
            $display("wb cycle %0d req=%0d wr=%0d addr=0x%0h rd_idx=%0d", c, mem_req_o, mem_wr_o, mem_addr_o, vc_rd_idx_o);
            chk("wb_req", {31'd0, mem_req_o}, 32'd1);
            chk("wb_memwr", {31'd0, mem_wr_o}, 32'd1);
            chk("wb_addr", {6'd0, mem_addr_o}, 32'h200);
            chk("wb_rdidx", {30'd0, vc_rd_idx_o}, 32'd1);
            chk("wb_rdy", {31'd0, insert_ready_o}, 32'd0);
            chk("wb_hitmask", {31'd0, victim_hit_o}, 32'd0);
            chk("wb_busy", {31'd0, busy_o}, 32'd1);
            tick();
        end
        mem_ack_i = 1'b0;
        #1;
        $display("wb insert wr=%0d idx=%0d rdy=%0d", vc_wr_o, vc_wr_idx_o, insert_ready_o);
        chk("wbins_wr", {31'd0, vc_wr_o}, 32'd1);
        chk("wbins_idx", {30'd0, vc_wr_idx_o}, 32'd1);
        chk("wbins_rdy", {31'd0, insert_ready_o}, 32'd1);
        chk("wbins_req", {31'd0, mem_req_o}, 32'd0);
        tick();
        insert_req_i = 1'b0;
        chk("wbdone_busy", {31'd0, busy_o}, 32'd0);
        lookup(26'h600, 1'b1, 2'd1);
        lookup(26'h200, 1'b0, 2'd0);

        // Ack outside writeback is ignored
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("stray_ack_busy", {31'd0, busy_o}, 32'd0);

        // Swap: take 0x300 at idx 2 while inserting 0x900 (rr 2 -> 3)
        swap_ins(26'h300, 26'h900, 1'b0, 2'd2);
        lookup(26'h300, 1'b0, 2'd0);
        lookup(26'h900, 1'b1, 2'd2);

        // Make idx 0 and idx 3 dirty via swaps (rr 3 -> 0)
        swap_ins(26'h500, 26'h500, 1'b1, 2'd0);
        swap_ins(26'h400, 26'h400, 1'b1, 2'd3);

        // Flush: writebacks idx 0 then idx 3
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_scan0_req", {31'd0, mem_req_o}, 32'd0);
        chk("fl_scan0_busy", {31'd0, busy_o}, 32'd1);
        tick();
        mem_ack_i = 1'b1;
        #1;
        $display("flush wb0 req=%0d addr=0x%0h rd_idx=%0d", mem_req_o, mem_addr_o, vc_rd_idx_o);
        chk("fl_wb0_req", {31'd0, mem_req_o}, 32'd1);
        chk("fl_wb0_addr", {6'd0, mem_addr_o}, 32'h500);
        chk("fl_wb0_idx", {30'd0, vc_rd_idx_o}, 32'd0);
        chk("fl_wb0_done", {31'd0, flush_done_o}, 32'd0);
        tick();
        mem_ack_i = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            #1;
            chk("fl_scan_req", {31'd0, mem_req_o}, 32'd0);
            chk("fl_scan_done", {31'd0, flush_done_o}, 32'd0);
            tick();
        end
        mem_ack_i = 1'b1;
        #1;
        $display("flush wb3 req=%0d addr=0x%0h rd_idx=%0d done=%0d", mem_req_o, mem_addr_o, vc_rd_idx_o, flush_done_o);
        chk("fl_wb3_req", {31'd0, mem_req_o}, 32'd1);
        chk("fl_wb3_addr", {6'd0, mem_addr_o}, 32'h400);
        chk("fl_wb3_idx", {30'd0, vc_rd_idx_o}, 32'd3);
        chk("fl_done", {31'd0, flush_done_o}, 32'd1);
        tick();
        mem_ack_i = 1'b0;
        #1;
        chk("fl_done_once", {31'd0, flush_done_o}, 32'd0);
        chk("fl_idle", {31'd0, busy_o}, 32'd0);
        lookup(26'h500, 1'b0, 2'd0);
        lookup(26'h600, 1'b0, 2'd0);
        lookup(26'h900, 1'b0, 2'd0);
        lookup(26'h400, 1'b0, 2'd0);

        // Refill after flush (rr restarts at 0), idx 0 dirty
        ins_ok(26'hA00, 1'b1, 2'd0);
        ins_ok(26'hB00, 1'b0, 2'd1);
        ins_ok(26'hC00, 1'b0, 2'd2);
        ins_ok(26'hD00, 1'b0, 2'd3);

        // Take alone invalidates idx 1, then reinsert fills the hole
        lookup_addr_i = 26'hB00; take_i = 1'b1;
        #1;
        chk("take_hit", {31'd0, victim_hit_o}, 32'd1);
        chk("take_idx", {30'd0, hit_idx_o}, 32'd1);
        chk("take_rdy", {31'd0, insert_ready_o}, 32'd0);
        tick();
        take_i = 1'b0;
        lookup(26'hB00, 1'b0, 2'd0);
        ins_ok(26'hB00, 1'b0, 2'd1);

        // Kill during writeback of dirty idx 0 (rr = 0)
        insert_req_i = 1'b1; insert_addr_i = 26'hE00; insert_dirty_i = 1'b0;
        tick();
        #1;
        chk("kwb_req", {31'd0, mem_req_o}, 32'd1);
        chk("kwb_addr", {6'd0, mem_addr_o}, 32'hA00);
        kill_i = 1'b1;
        #1;
        $display("kill req=%0d kill_o=%0d rdy=%0d", mem_req_o, mem_kill_o, insert_ready_o);
        chk("kill_req", {31'd0, mem_req_o}, 32'd0);
        chk("kill_pulse", {31'd0, mem_kill_o}, 32'd1);
        chk("kill_rdy", {31'd0, insert_ready_o}, 32'd0);
        tick();
        kill_i = 1'b0; insert_req_i = 1'b0;
        #1;
        chk("kill_busy", {31'd0, busy_o}, 32'd0);
        chk("kill_once", {31'd0, mem_kill_o}, 32'd0);
        lookup(26'hA00, 1'b1, 2'd0);
        lookup(26'hE00, 1'b0, 2'd0);

        // Reset in the middle of a writeback
        insert_req_i = 1'b1; insert_addr_i = 26'hE00;
        tick();
        #1;
        chk("rwb_req", {31'd0, mem_req_o}, 32'd1);
        rst_n = 1'b0; insert_req_i = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rwb_busy", {31'd0, busy_o}, 32'd0);
        chk("rwb_req_off", {31'd0, mem_req_o}, 32'd0);
        chk("rwb_kill", {31'd0, mem_kill_o}, 32'd0);
        lookup(26'hA00, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
